// File: rtl/secuenciador_prog.sv
// Program sequencer: fetches 8-bit words from a synchronous ROM and drives the
// control unit's 3-bit opcode for EXEC_CYCLES clocks; JMP/HALT are resolved here.
module secuenciador_prog #(
  parameter int AW          = 5,
  parameter int EXEC_CYCLES = 3
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          run,
  input  logic          halt_req,
  input  logic          single_step,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  output logic [2:0]    instruction,
  output logic          exec_valid,
  output logic [1:0]    phase,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic [7:0]    retired
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    DECODE,
    EXEC,
    HALTED
  } state_t;

  localparam logic [2:0] OP_IDLE    = 3'b100;
  localparam logic [2:0] OP_JMP     = 3'b100;
  localparam logic [2:0] OP_HALT    = 3'b101;
  localparam logic [1:0] LAST_PHASE = 2'(EXEC_CYCLES - 1);

  state_t     state;
  logic [7:0] ir;
  logic       stop_at_boundary;

  assign rom_addr = pc;

  // A finished instruction (or a JMP) parks in IDLE on halt_req or single-step.
  assign stop_at_boundary = halt_req || single_step;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= 8'h80;
      instruction <= OP_IDLE;
      exec_valid  <= 1'b0;
      phase       <= 2'd0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      retired     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (run && !halt_req) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          ir    <= rom_data;
          state <= DECODE;
        end
        DECODE: begin
          case (ir[7:5])
            OP_HALT: begin
              state  <= HALTED;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
            OP_JMP: begin
              pc    <= AW'(ir[4:0]);
              state <= stop_at_boundary ? IDLE : FETCH;
              busy  <= !stop_at_boundary;
            end
            default: begin
              state       <= EXEC;
              instruction <= ir[7:5];
              exec_valid  <= 1'b1;
              phase       <= 2'd0;
            end
          endcase
        end
        EXEC: begin
          // The control unit must see the idle opcode again as soon as the op retires.
          if (phase == LAST_PHASE) begin
            pc          <= pc + AW'(1);
            retired     <= retired + 8'd1;
            instruction <= OP_IDLE;
            exec_valid  <= 1'b0;
            phase       <= 2'd0;
            state       <= stop_at_boundary ? IDLE : FETCH;
            busy        <= !stop_at_boundary;
          end else begin
            phase <= phase + 2'd1;
          end
        end
        HALTED: begin
          if (run) begin
            pc     <= pc + AW'(1);
            state  <= FETCH;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_prog.sv
// Self-checking bench for secuenciador_prog: per-cycle vector tables plus
// hand-written sequences for free-run wrap and asynchronous clear.
module tb_secuenciador_prog;

  logic       clk;
  logic       clear_n;
  logic       run;
  logic       halt_req;
  logic       single_step;
  logic [4:0] rom_addr;
  logic [7:0] rom_data;
  logic [2:0] instruction;
  logic       exec_valid;
  logic [1:0] phase;
  logic [4:0] pc;
  logic       busy;
  logic       halted;
  logic [7:0] retired;

  logic [7:0] rom_mem [0:31];

  int total_checks;
  int passed_checks;

  typedef struct {
    logic       run;
    logic       halt_req;
    logic       single_step;
    logic [2:0] e_instr;
    logic       e_valid;
    logic [1:0] e_phase;
    logic [4:0] e_pc;
    logic       e_busy;
    logic       e_halted;
    logic [7:0] e_retired;
  } vec_t;

  vec_t vecs[$];

  secuenciador_prog #(.AW(5), .EXEC_CYCLES(3)) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .run         (run),
    .halt_req    (halt_req),
    .single_step (single_step),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instruction (instruction),
    .exec_valid  (exec_valid),
    .phase       (phase),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROM: word appears one clock after its address.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic addVec(input logic r, input logic h, input logic s, input logic [2:0] ins,
                        input logic v, input logic [1:0] ph, input logic [4:0] p,
                        input logic b, input logic hl, input logic [7:0] ret);
    vec_t t;
    t.run = r; t.halt_req = h; t.single_step = s;
    t.e_instr = ins; t.e_valid = v; t.e_phase = ph; t.e_pc = p;
    t.e_busy = b; t.e_halted = hl; t.e_retired = ret;
    vecs.push_back(t);
  endtask

  // Drives one vector's inputs at a falling edge and lets one rising edge pass.
  task automatic applyStimulus(input vec_t v);
    run         = v.run;
    halt_req    = v.halt_req;
    single_step = v.single_step;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    checkVal(name,
             {instruction, exec_valid, phase, pc, busy, halted, retired, rom_addr},
             {v.e_instr, v.e_valid, v.e_phase, v.e_pc, v.e_busy, v.e_halted, v.e_retired, v.e_pc});
  endtask

  task automatic runTable(input string name);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("%s[%0d]", name, i), vecs[i]);
    end
    vecs.delete();
  endtask

  task automatic doReset();
    run = 1'b0; halt_req = 1'b0; single_step = 1'b0;
    clear_n = 1'b0;
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic fillRom(input logic [7:0] word);
    for (int i = 0; i < 32; i++) rom_mem[i] = word;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    fillRom(8'h00);
    doReset();

    checkVal("reset_state",
             {instruction, exec_valid, phase, pc, busy, halted, retired},
             {3'b100, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 8'd0});

    // One datapath op then HALT; resume from HALTED skips the HALT word.
    fillRom(8'h00);
    rom_mem[0] = 8'h60; rom_mem[1] = 8'hA0;
    doReset();
    //     run h  s  instr   v  ph pc  busy hlt ret
    addVec(1, 0, 0, 3'b100, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 3'b100, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 3'b100, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 3'b011, 1, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 3'b011, 1, 1, 0, 1, 0, 0);
    addVec(0, 0, 0, 3'b011, 1, 2, 0, 1, 0, 0);
    addVec(0, 0, 0, 3'b100, 0, 0, 1, 1, 0, 1);
    addVec(0, 0, 0, 3'b100, 0, 0, 1, 1, 0, 1);
    addVec(0, 0, 0, 3'b100, 0, 0, 1, 1, 0, 1);
    addVec(0, 0, 0, 3'b100, 0, 0, 1, 0, 1, 1);
    addVec(0, 1, 0, 3'b100, 0, 0, 1, 0, 1, 1);
    addVec(1, 0, 0, 3'b100, 0, 0, 2, 1, 0, 1);
    runTable("op_then_halt");

    // JMP to 5, op 001, HALT at 6.
    fillRom(8'h00);
    rom_mem[0] = 8'h85; rom_mem[5] = 8'h20; rom_mem[6] = 8'hA0;
    doReset();
    addVec(1, 0, 0, 3'b100, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 3'b100, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 3'b100, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 3'b100, 0, 0, 5, 1, 0, 0);
    addVec(0, 0, 0, 3'b100, 0, 0, 5, 1, 0, 0);
    addVec(0, 0, 0, 3'b100, 0, 0, 5, 1, 0, 0);
    addVec(0, 0, 0, 3'b001, 1, 0, 5, 1, 0, 0);
    addVec(0, 0, 0, 3'b001, 1, 1, 5, 1, 0, 0);
    addVec(0, 0, 0, 3'b001, 1, 2, 5, 1, 0, 0);
    addVec(0, 0, 0, 3'b100, 0, 0, 6, 1, 0, 1);
    addVec(0, 0, 0, 3'b100, 0, 0, 6, 1, 0, 1);
    addVec(0, 0, 0, 3'b100, 0, 0, 6, 1, 0, 1);
    addVec(0, 0, 0, 3'b100, 0, 0, 6, 0, 1, 1);
    runTable("jmp");

    // Single-step: one op 111 per run pulse, IDLE in between.
    fillRom(8'h00);
    for (int i = 0; i < 3; i++) rom_mem[i] = 8'hE0;
    doReset();
    for (int k = 0; k < 3; k++) begin
      addVec(1, 0, 1, 3'b100, 0, 0, 5'(k), 1, 0, 8'(k));
      addVec(0, 0, 1, 3'b100, 0, 0, 5'(k), 1, 0, 8'(k));
      addVec(0, 0, 1, 3'b100, 0, 0, 5'(k), 1, 0, 8'(k));
      addVec(0, 0, 1, 3'b111, 1, 0, 5'(k), 1, 0, 8'(k));
      addVec(0, 0, 1, 3'b111, 1, 1, 5'(k), 1, 0, 8'(k));
      addVec(0, 0, 1, 3'b111, 1, 2, 5'(k), 1, 0, 8'(k));
      addVec(0, 0, 1, 3'b100, 0, 0, 5'(k + 1), 0, 0, 8'(k + 1));
      addVec(0, 0, 1, 3'b100, 0, 0, 5'(k + 1), 0, 0, 8'(k + 1));
    end
    runTable("single_step");

    // halt_req raised at EXEC phase 0 lets the op finish, then parks in IDLE.
    fillRom(8'h00);
    doReset();
    addVec(1, 0, 0, 3'b100, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 3'b100, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 3'b100, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 3'b000, 1, 0, 0, 1, 0, 0);
    addVec(0, 1, 0, 3'b000, 1, 1, 0, 1, 0, 0);
    addVec(0, 1, 0, 3'b000, 1, 2, 0, 1, 0, 0);
    addVec(0, 1, 0, 3'b100, 0, 0, 1, 0, 0, 1);
    addVec(0, 0, 0, 3'b100, 0, 0, 1, 0, 0, 1);
    addVec(1, 1, 0, 3'b100, 0, 0, 1, 0, 0, 1);
    addVec(1, 1, 0, 3'b100, 0, 0, 1, 0, 0, 1);
    runTable("halt_req");

    // Free run of 40 ops over an all-zero program: pc wraps 31 -> 0.
    begin
      bit saw31;
      bit wrapped;
      saw31 = 0; wrapped = 0;
      fillRom(8'h00);
      doReset();
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      for (int i = 0; i < 400 && retired != 8'd40; i++) begin
        @(negedge clk);
        if (pc == 5'd31) saw31 = 1;
        if (saw31 && pc == 5'd0) wrapped = 1;
      end
      checkVal("freerun_retired", 32'(retired), 32'd40);
      checkVal("freerun_pc", 32'(pc), 32'd8);
      checkVal("freerun_wrap", 32'(wrapped), 32'd1);
      halt_req = 1'b1;
      for (int i = 0; i < 20 && busy; i++) @(negedge clk);
      halt_req = 1'b0;
      checkVal("freerun_stop", {busy, halted, pc, retired}, {1'b0, 1'b0, 5'd9, 8'd41});
    end

    // Asynchronous clear in the middle of the second op's EXEC phase 1.
    fillRom(8'h00);
    doReset();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 50 && !(retired == 8'd1 && exec_valid && phase == 2'd1); i++) @(negedge clk);
    checkVal("clear_precond", {retired, exec_valid, phase, pc}, {8'd1, 1'b1, 2'd1, 5'd1});
    #2 clear_n = 1'b0;
    #1;
    checkVal("clear_async",
             {instruction, exec_valid, phase, pc, busy, halted, retired},
             {3'b100, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 8'd0});
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    checkVal("clear_idle", {busy, instruction, pc}, {1'b0, 3'b100, 5'd0});

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
